// File: rtl/wb_dma_pkg.sv
// wb_dma_pkg: register map, CTRL/STATUS bit positions and FSM states for wb_dma_copy.
package wb_dma_pkg;
  localparam logic [2:0] REG_SRC    = 3'd0;
  localparam logic [2:0] REG_DST    = 3'd1;
  localparam logic [2:0] REG_LEN    = 3'd2;
  localparam logic [2:0] REG_CTRL   = 3'd3;
  localparam logic [2:0] REG_REMAIN = 3'd4;
  localparam int CTRL_START   = 0;
  localparam int CTRL_IRQ_EN  = 1;
  localparam int CTRL_IRQ_CLR = 2;
  localparam int ST_BUSY   = 0;
  localparam int ST_DONE   = 1;
  localparam int ST_ERR    = 2;
  localparam int ST_IRQ_EN = 3;
  localparam int ST_IRQ    = 4;
  typedef enum logic [2:0] {S_IDLE, S_RD, S_RD_GAP, S_WR, S_WR_GAP} state_t;
endpackage

// File: rtl/wb_dma_regs.sv
// wb_dma_regs: responder decode, register file and ack for wb_dma_copy.
// Interrupt enable/pending bits exist only when WB_DMA_IRQ_EN is defined.
module wb_dma_regs
  import wb_dma_pkg::*;
#(
  parameter int LEN_W = 12
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [2:0]       wbs_adr_i,
  input  logic [31:0]      wbs_dat_i,
  input  logic             wbs_we_i,
  input  logic             wbs_cyc_i,
  input  logic             wbs_stb_i,
  output logic [31:0]      wbs_dat_o,
  output logic             wbs_ack_o,
  input  logic             busy_i,
  input  logic [LEN_W-1:0] remain_i,
  input  logic             done_set_i,
  input  logic             err_set_i,
  output logic [31:0]      src_o,
  output logic [31:0]      dst_o,
  output logic [LEN_W-1:0] len_o,
  output logic             start_o
`ifdef WB_DMA_IRQ_EN
  ,
  output logic             irq_o
`endif
);
  logic ack_q, done_q, done_d, err_q, err_d;
  logic [31:0] dat_q, src_q, src_d, dst_q, dst_d, rdata, status;
  logic [LEN_W-1:0] len_q, len_d;
  logic wr, cfg, go, zgo, ctrl;
`ifdef WB_DMA_IRQ_EN
  logic ien_q, ien_d, pend_q, pend_d;
`endif
  // writes commit in the ack cycle so a START acked at t strobes the initiator at t+1
  assign wr      = wbs_cyc_i & wbs_stb_i & wbs_we_i & ack_q;
  assign cfg     = wr & ~busy_i;
  assign ctrl    = wr & (wbs_adr_i == REG_CTRL);
  assign go      = cfg & (wbs_adr_i == REG_CTRL) & wbs_dat_i[CTRL_START];
  assign start_o = go & (len_q != '0);
  assign zgo     = go & (len_q == '0);
  always_comb begin
    src_d  = (cfg && wbs_adr_i == REG_SRC) ? {wbs_dat_i[31:2], 2'b00} : src_q;
    dst_d  = (cfg && wbs_adr_i == REG_DST) ? {wbs_dat_i[31:2], 2'b00} : dst_q;
    len_d  = (cfg && wbs_adr_i == REG_LEN) ? wbs_dat_i[LEN_W-1:0] : len_q;
    done_d = (done_set_i | zgo) ? 1'b1 : start_o ? 1'b0 : done_q;
    err_d  = err_set_i ? 1'b1 : go ? 1'b0 : err_q;
    status = '0;
    status[ST_BUSY] = busy_i;
    status[ST_DONE] = done_q;
    status[ST_ERR]  = err_q;
`ifdef WB_DMA_IRQ_EN
    ien_d  = ctrl ? wbs_dat_i[CTRL_IRQ_EN] : ien_q;
    pend_d = (done_set_i | err_set_i | zgo) ? 1'b1 : (ctrl & wbs_dat_i[CTRL_IRQ_CLR]) ? 1'b0 : pend_q;
    status[ST_IRQ_EN] = ien_q;
    status[ST_IRQ]    = pend_q;
`endif
    rdata = (wbs_adr_i == REG_SRC)    ? src_q :
            (wbs_adr_i == REG_DST)    ? dst_q :
            (wbs_adr_i == REG_LEN)    ? {{(32-LEN_W){1'b0}}, len_q} :
            (wbs_adr_i == REG_CTRL)   ? status :
            (wbs_adr_i == REG_REMAIN) ? {{(32-LEN_W){1'b0}}, remain_i} : '0;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ack_q  <= 1'b0;
      dat_q  <= '0;
      src_q  <= '0;
      dst_q  <= '0;
      len_q  <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
`ifdef WB_DMA_IRQ_EN
      ien_q  <= 1'b0;
      pend_q <= 1'b0;
`endif
    end else begin
      ack_q  <= wbs_cyc_i & wbs_stb_i & ~ack_q;
      dat_q  <= (wbs_cyc_i & wbs_stb_i & ~ack_q) ? rdata : dat_q;
      src_q  <= src_d;
      dst_q  <= dst_d;
      len_q  <= len_d;
      done_q <= done_d;
      err_q  <= err_d;
`ifdef WB_DMA_IRQ_EN
      ien_q  <= ien_d;
      pend_q <= pend_d;
`endif
    end
  end
  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign src_o     = src_q;
  assign dst_o     = dst_q;
  assign len_o     = len_q;
`ifdef WB_DMA_IRQ_EN
  assign irq_o     = pend_q & ien_q;
`endif
endmodule

// File: rtl/wb_dma_copy.sv
// wb_dma_copy: word-granular Wishbone memory-to-memory copy engine (initiator FSM and datapath).
// Defining WB_DMA_IRQ_EN adds the o_irq completion interrupt.
module wb_dma_copy
  import wb_dma_pkg::*;
#(
  parameter logic [31:0] BASE_ADR = 32'h30ff_fc00,
  parameter int          LEN_W    = 12
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic        wbs_we_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_we_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i
`ifdef WB_DMA_IRQ_EN
  ,
  output logic        o_irq
`endif
);
  state_t state_q, state_d;
  logic [31:0] src_q, src_d, dst_q, dst_d, buf_q, buf_d, adr_q, adr_d, cfg_src, cfg_dst;
  logic [LEN_W-1:0] rem_q, rem_d, cfg_len;
  logic [3:0] sel_q;
  logic we_q, stb_d, start, done_set, err_set;
  logic unused;
  // the interconnect decodes BASE_ADR; only the word offset reaches the register file
  assign unused = ^{BASE_ADR, wbs_adr_i[31:5], wbs_adr_i[1:0], wbs_sel_i};
  wb_dma_regs #(.LEN_W(LEN_W)) u_regs (
    .clk_i      (wb_clk_i),
    .rst_i      (wb_rst_i),
    .wbs_adr_i  (wbs_adr_i[4:2]),
    .wbs_dat_i  (wbs_dat_i),
    .wbs_we_i   (wbs_we_i),
    .wbs_cyc_i  (wbs_cyc_i),
    .wbs_stb_i  (wbs_stb_i),
    .wbs_dat_o  (wbs_dat_o),
    .wbs_ack_o  (wbs_ack_o),
    .busy_i     (state_q != S_IDLE),
    .remain_i   (rem_q),
    .done_set_i (done_set),
    .err_set_i  (err_set),
    .src_o      (cfg_src),
    .dst_o      (cfg_dst),
    .len_o      (cfg_len),
    .start_o    (start)
`ifdef WB_DMA_IRQ_EN
    ,
    .irq_o      (o_irq)
`endif
  );
  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    dst_d    = dst_q;
    rem_d    = rem_q;
    buf_d    = buf_q;
    done_set = 1'b0;
    err_set  = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_RD;
        src_d   = cfg_src;
        dst_d   = cfg_dst;
        rem_d   = cfg_len;
      end
      S_RD: if (wbm_err_i) begin
        state_d = S_IDLE;
        err_set = 1'b1;
      end else if (wbm_ack_i) begin
        state_d = S_RD_GAP;
        buf_d   = wbm_dat_i;
      end
      S_RD_GAP: state_d = S_WR;
      S_WR: if (wbm_err_i) begin
        state_d = S_IDLE;
        err_set = 1'b1;
      end else if (wbm_ack_i) begin
        state_d = S_WR_GAP;
        src_d   = src_q + 32'd4;
        dst_d   = dst_q + 32'd4;
        rem_d   = rem_q - LEN_W'(1);
      end
      S_WR_GAP: begin
        state_d  = (rem_q == '0) ? S_IDLE : S_RD;
        done_set = (rem_q == '0);
      end
      default: state_d = S_IDLE;
    endcase
    stb_d = (state_d == S_RD) | (state_d == S_WR);
    adr_d = (state_d == S_WR) ? dst_d : src_d;
  end
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      buf_q   <= '0;
      adr_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      buf_q   <= buf_d;
      adr_q   <= adr_d;
      sel_q   <= stb_d ? 4'hf : 4'h0;
      we_q    <= (state_d == S_WR);
    end
  end
  // cyc/stb decode straight from state so an async reset drops them at once
  assign wbm_cyc_o = (state_q == S_RD) | (state_q == S_WR);
  assign wbm_stb_o = wbm_cyc_o;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = buf_q;
  assign wbm_sel_o = sel_q;
  assign wbm_we_o  = we_q;
endmodule

// File: tb/tb_wb_dma_copy.sv
// tb_wb_dma_copy: scoreboard bench for wb_dma_copy with a 1-cycle-ack memory model.
module tb_wb_dma_copy;
  localparam logic [31:0] BASE = 32'h30ff_fc00;
`ifdef WB_DMA_IRQ_EN
  localparam bit HAS_IRQ = 1'b1;
`else
  localparam bit HAS_IRQ = 1'b0;
`endif
  typedef struct {string nm; logic [31:0] v;} rd_t;
  typedef struct {logic [31:0] a; logic [31:0] d;} wr_t;
  logic wb_clk_i = 1'b0, wb_rst_i = 1'b1;
  logic [31:0] wbs_adr_i = '0, wbs_dat_i = '0;
  logic wbs_we_i = 1'b0, wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0;
  logic [31:0] wbs_dat_o, wbm_adr_o, wbm_dat_o;
  logic wbs_ack_o, wbm_we_o, wbm_cyc_o, wbm_stb_o;
  logic [3:0] wbm_sel_o;
  logic [31:0] rdat = '0;
  logic mack = 1'b0, merr = 1'b0;
`ifdef WB_DMA_IRQ_EN
  logic o_irq;
`endif
  logic [31:0] mem [256];
  rd_t exp_rd[$];
  wr_t exp_wr[$];
  int n_vec = 0, n_err = 0, cyc_n = 0, n_cyc = 0, stb_rise = 0;
  int rd_cnt = 0, wr_cnt = 0, err_rd = 0, t_ack = 0;
  logic stb_p = 1'b0, pend = 1'b0, ien = 1'b0;

  wb_dma_copy dut (
    .wb_clk_i (wb_clk_i), .wb_rst_i (wb_rst_i),
    .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_sel_i(4'hf),
    .wbs_we_i (wbs_we_i), .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i),
    .wbs_dat_o(wbs_dat_o), .wbs_ack_o(wbs_ack_o),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
    .wbm_we_o (wbm_we_o), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
    .wbm_dat_i(rdat), .wbm_ack_i(mack), .wbm_err_i(merr)
`ifdef WB_DMA_IRQ_EN
    , .o_irq(o_irq)
`endif
  );

  always #5 wb_clk_i = ~wb_clk_i;
  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, required finish before 100us");
    $fatal(1);
  end

  function automatic logic [31:0] pat(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction
  function automatic logic [31:0] stat(input logic b, input logic d, input logic e);
    return {27'd0, pend & HAS_IRQ, ien & HAS_IRQ, e, d, b};
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask
  task automatic fail(input string nm, input string got, input string req);
    n_vec++;
    n_err++;
    $display("FAIL %s: got %s required %s", nm, got, req);
  endtask

  // memory model: request taken at a clock edge, ack/err one cycle later
  always @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      mack <= 1'b0;
      merr <= 1'b0;
    end else begin
      mack <= 1'b0;
      merr <= 1'b0;
      if (wbm_cyc_o && wbm_stb_o && !mack && !merr) begin
        if (!wbm_we_o) begin
          rd_cnt <= rd_cnt + 1;
          if (rd_cnt + 1 == err_rd) merr <= 1'b1;
          else begin
            mack <= 1'b1;
            rdat <= pat(wbm_adr_o);
          end
        end else begin
          mack <= 1'b1;
          wr_cnt <= wr_cnt + 1;
          mem[wbm_adr_o[9:2]] <= wbm_dat_o;
        end
      end
    end
  end
  always @(posedge wb_clk_i) cyc_n <= cyc_n + 1;

  // monitor: pops the scoreboard whenever either port presents a result
  always @(negedge wb_clk_i) begin
    rd_t r;
    wr_t w;
    if (wbm_stb_o && !stb_p) stb_rise = cyc_n;
    stb_p = wbm_stb_o;
    if (wbm_cyc_o) n_cyc++;
    if (wbs_ack_o && !wbs_we_i) begin
      if (exp_rd.size() == 0) fail("unexpected_rd", $sformatf("%h", wbs_dat_o), "no read");
      else begin
        r = exp_rd.pop_front();
        chk(r.nm, wbs_dat_o, r.v);
      end
    end
    if (wbm_cyc_o && wbm_stb_o && wbm_we_o && mack) begin
      if (exp_wr.size() == 0) fail("unexpected_wr", $sformatf("%h@%h", wbm_dat_o, wbm_adr_o), "no write");
      else begin
        w = exp_wr.pop_front();
        chk("wr_adr", wbm_adr_o, w.a);
        chk("wr_dat", wbm_dat_o, w.d);
        chk("wr_sel", {28'd0, wbm_sel_o}, 32'hf);
      end
    end
  end

  task automatic acc(input logic [4:0] off, input logic we, input logic [31:0] d);
    bit got = 1'b0;
    wbs_adr_i = BASE | {27'd0, off};
    wbs_dat_i = d;
    wbs_we_i  = we;
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge wb_clk_i);
      got = wbs_ack_o;
    end
    if (!got) fail("ack_timeout", "no ack", "ack within 8 cycles");
    t_ack = cyc_n;
    @(posedge wb_clk_i);
    #1;
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_we_i  = 1'b0;
  endtask
  task automatic wr(input logic [4:0] off, input logic [31:0] d);
    acc(off, 1'b1, d);
  endtask
  task automatic rd(input logic [4:0] off, input string nm, input logic [31:0] exp);
    exp_rd.push_back('{nm, exp});
    acc(off, 1'b0, '0);
  endtask

  initial begin
    int t, r0, w0, c0;
    bit seen;
    repeat (3) @(posedge wb_clk_i);
    #1 wb_rst_i = 1'b0;
    chk("rst_cyc", {31'd0, wbm_cyc_o}, 0);
    chk("rst_adr", wbm_adr_o, 0);
    rd(5'h00, "rst_src", 0);
    rd(5'h04, "rst_dst", 0);
    rd(5'h08, "rst_len", 0);
    rd(5'h0c, "rst_stat", stat(0, 0, 0));
    rd(5'h10, "rst_rem", 0);
    // 4-word copy, alignment masking and LEN truncation
    wr(5'h00, 32'h3000_1003);
    wr(5'h04, 32'h3000_1100);
    wr(5'h08, 32'h0000_1004);
    rd(5'h00, "src_align", 32'h3000_1000);
    rd(5'h08, "len_trunc", 32'd4);
    rd(5'h14, "unmapped", 0);
    for (int i = 0; i < 4; i++) exp_wr.push_back('{32'h3000_1100 + 4 * i, pat(32'h3000_1000 + 4 * i)});
    r0 = rd_cnt;
    w0 = wr_cnt;
    wr(5'h0c, 32'h1);
    t = t_ack;
    pend = 1'b1;
    @(negedge wb_clk_i);
    #1 chk("first_stb", stb_rise, t + 1);
    @(posedge wb_clk_i);
    #1;
    repeat (23) @(posedge wb_clk_i);
    #1 rd(5'h0c, "t25_stat", stat(0, 1, 0));
    chk("n_rd", rd_cnt - r0, 4);
    chk("n_wr", wr_cnt - w0, 4);
    rd(5'h10, "rem_done", 0);
    for (int i = 0; i < 4; i++) chk("dst_mem", mem[8'h40 + i], pat(32'h3000_1000 + 4 * i));
    // bus error on the second read
    wr(5'h04, 32'h3000_1200);
    exp_wr.push_back('{32'h3000_1200, pat(32'h3000_1000)});
    w0 = wr_cnt;
    err_rd = rd_cnt + 2;
    wr(5'h0c, 32'h1);
    repeat (20) @(posedge wb_clk_i);
    #1 rd(5'h0c, "err_stat", stat(0, 0, 1));
    rd(5'h10, "err_rem", 32'd3);
    chk("err_nwr", wr_cnt - w0, 1);
    err_rd = 0;
    // zero length
    c0 = n_cyc;
    wr(5'h08, 32'h0);
    wr(5'h0c, 32'h1);
    rd(5'h0c, "len0_stat", stat(0, 1, 0));
    chk("len0_cyc", n_cyc - c0, 0);
    // config writes ignored while busy
    wr(5'h04, 32'h3000_1300);
    wr(5'h08, 32'h3);
    for (int i = 0; i < 3; i++) exp_wr.push_back('{32'h3000_1300 + 4 * i, pat(32'h3000_1000 + 4 * i)});
    wr(5'h0c, 32'h1);
    wr(5'h00, 32'hdead_beec);
    rd(5'h00, "busy_src", 32'h3000_1000);
    rd(5'h0c, "busy_stat", stat(1, 0, 0));
    repeat (20) @(posedge wb_clk_i);
    #1 rd(5'h0c, "busy_done", stat(0, 1, 0));
    rd(5'h00, "busy_src2", 32'h3000_1000);
    // asynchronous reset during the first write
    wr(5'h04, 32'h3000_1340);
    wr(5'h08, 32'h2);
    wr(5'h0c, 32'h1);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge wb_clk_i);
      seen = wbm_cyc_o & wbm_we_o;
    end
    if (!seen) fail("wr_wait", "no write cycle", "write within 20 cycles");
    wb_rst_i = 1'b1;
    #1 chk("arst_cyc", {31'd0, wbm_cyc_o}, 0);
    chk("arst_stb", {31'd0, wbm_stb_o}, 0);
    pend = 1'b0;
    ien = 1'b0;
    @(posedge wb_clk_i);
    #1 wb_rst_i = 1'b0;
    rd(5'h00, "arst_src", 0);
    rd(5'h04, "arst_dst", 0);
    rd(5'h08, "arst_len", 0);
    rd(5'h0c, "arst_stat", stat(0, 0, 0));
    rd(5'h10, "arst_rem", 0);
    // interrupt enable/clear
    wr(5'h00, 32'h3000_1000);
    wr(5'h04, 32'h3000_1380);
    wr(5'h08, 32'h2);
    for (int i = 0; i < 2; i++) exp_wr.push_back('{32'h3000_1380 + 4 * i, pat(32'h3000_1000 + 4 * i)});
    wr(5'h0c, 32'h3);
    ien = 1'b1;
    pend = 1'b1;
`ifdef WB_DMA_IRQ_EN
    repeat (12) @(negedge wb_clk_i);
    chk("irq_t12", {31'd0, o_irq}, 0);
    @(negedge wb_clk_i);
    chk("irq_t13", {31'd0, o_irq}, 1);
    @(posedge wb_clk_i);
    #1;
`else
    repeat (14) @(posedge wb_clk_i);
    #1;
`endif
    rd(5'h0c, "irq_stat", stat(0, 1, 0));
`ifdef WB_DMA_IRQ_EN
    chk("irq_hold", {31'd0, o_irq}, 1);
`endif
    wr(5'h0c, 32'h6);
    pend = 1'b0;
`ifdef WB_DMA_IRQ_EN
    chk("irq_clr", {31'd0, o_irq}, 0);
`endif
    rd(5'h0c, "clr_stat", stat(0, 1, 0));
    repeat (5) @(posedge wb_clk_i);
    #1 chk("rdq_empty", exp_rd.size(), 0);
    chk("wrq_empty", exp_wr.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
